// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate byte cache: 8 lines x 4 bytes.
// A miss on a dirty line writes the old block back before fetching the new one.
module dcache_controller (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_read,
    input  logic        cpu_write,
    input  logic [7:0]  cpu_address,
    input  logic [7:0]  cpu_writedata,
    output logic [7:0]  cpu_readdata,
    output logic        cpu_busywait,
    output logic        mem_read,
    output logic        mem_write,
    output logic [5:0]  mem_address,
    output logic [31:0] mem_writedata,
    input  logic [31:0] mem_readdata,
    input  logic        mem_busywait
);

    typedef enum logic [1:0] {StIdle, StWriteback, StFetch} state_e;

    state_e      r_state;
    state_e      w_next_state;
    logic [7:0]  r_valid;
    logic [7:0]  r_dirty;
    logic [2:0]  r_tag  [8];
    logic [31:0] r_data [8];

    logic [2:0]  w_tag;
    logic [2:0]  w_index;
    logic [4:0]  w_bit_sel;
    logic        w_access;
    logic        w_hit;
    logic        w_read_hit;
    logic        w_write_hit;
    logic [31:0] w_line;

    assign w_tag       = cpu_address[7:5];
    assign w_index     = cpu_address[4:2];
    assign w_bit_sel   = {cpu_address[1:0], 3'b000};
    assign w_access    = cpu_read ^ cpu_write;
    assign w_hit       = r_valid[w_index] && (r_tag[w_index] == w_tag);
    assign w_read_hit  = (r_state == StIdle) && cpu_read && !cpu_write && w_hit;
    assign w_write_hit = (r_state == StIdle) && cpu_write && !cpu_read && w_hit;
    assign w_line      = r_data[w_index];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_access && !w_hit) begin
                    w_next_state = (r_valid[w_index] && r_dirty[w_index]) ? StWriteback : StFetch;
                end
            end
            StWriteback: if (!mem_busywait) w_next_state = StFetch;
            StFetch:     if (!mem_busywait) w_next_state = StIdle;
            default:     w_next_state = StIdle;
        endcase
    end

    // Outputs are gated by reset so they drop immediately, even with a CPU request held.
    always_comb begin
        cpu_busywait  = 1'b0;
        cpu_readdata  = 8'h00;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_address   = 6'h00;
        mem_writedata = 32'h0;
        if (!reset) begin
            unique case (r_state)
                StIdle: begin
                    cpu_busywait = w_access && !w_hit;
                    if (w_read_hit) cpu_readdata = w_line[w_bit_sel +: 8];
                end
                StWriteback: begin
                    cpu_busywait  = 1'b1;
                    mem_write     = 1'b1;
                    mem_address   = {r_tag[w_index], w_index};
                    mem_writedata = w_line;
                end
                StFetch: begin
                    cpu_busywait = 1'b1;
                    mem_read     = 1'b1;
                    mem_address  = {w_tag, w_index};
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_valid <= 8'h00;
            r_dirty <= 8'h00;
            for (int i = 0; i < 8; i++) begin
                r_tag[i]  <= 3'd0;
                r_data[i] <= 32'h0;
            end
        end else if (r_state == StFetch && !mem_busywait) begin
            r_data[w_index]  <= mem_readdata;
            r_tag[w_index]   <= w_tag;
            r_valid[w_index] <= 1'b1;
            r_dirty[w_index] <= 1'b0;
        end else if (w_write_hit) begin
            r_data[w_index][w_bit_sel +: 8] <= cpu_writedata;
            r_dirty[w_index]                <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller with a fixed-latency backing memory model.
// Untouched memory block a holds byte n = {n[1:0], a[5:0]}.
module tb_dcache_controller;

    localparam int Lat    = 2;
    localparam int Budget = 40;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_read = 1'b0;
    logic        cpu_write = 1'b0;
    logic [7:0]  cpu_address = 8'h00;
    logic [7:0]  cpu_writedata = 8'h00;
    logic [7:0]  cpu_readdata;
    logic        cpu_busywait;
    logic        mem_read;
    logic        mem_write;
    logic [5:0]  mem_address;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        mem_busywait;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] mem_store [64];
    logic [63:0] mem_written;
    int          mem_cnt;

    always #5 clock = ~clock;

    dcache_controller dut (
        .clock         (clock),
        .reset         (reset),
        .cpu_read      (cpu_read),
        .cpu_write     (cpu_write),
        .cpu_address   (cpu_address),
        .cpu_writedata (cpu_writedata),
        .cpu_readdata  (cpu_readdata),
        .cpu_busywait  (cpu_busywait),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata),
        .mem_busywait  (mem_busywait)
    );

    function automatic logic [31:0] default_block(input logic [5:0] a);
        return {2'd3, a, 2'd2, a, 2'd1, a, 2'd0, a};
    endfunction

    assign mem_busywait = (mem_read || mem_write) && (mem_cnt != Lat);

    always_comb begin
        mem_readdata = 32'h0;
        if (mem_read) begin
            mem_readdata = mem_written[mem_address] ? mem_store[mem_address]
                                                    : default_block(mem_address);
        end
    end

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_cnt <= 0;
        end else if (mem_read || mem_write) begin
            if (mem_cnt == Lat) begin
                mem_cnt <= 0;
                if (mem_write) begin
                    mem_store[mem_address]   <= mem_writedata;
                    mem_written[mem_address] <= 1'b1;
                end
            end else begin
                mem_cnt <= mem_cnt + 1;
            end
        end else begin
            mem_cnt <= 0;
        end
    end

    // Holds one request until cpu_busywait drops, logging any memory traffic seen.
    task automatic do_access(input logic rd, input logic wr, input logic [7:0] addr,
                             input logic [7:0] wdata, output int stalls,
                             output logic saw_wb, output logic [5:0] wb_addr,
                             output logic [31:0] wb_data, output logic saw_fetch,
                             output logic [5:0] f_addr, output logic [7:0] rdata);
        stalls = 0; saw_wb = 0; wb_addr = 0; wb_data = 0; saw_fetch = 0; f_addr = 0;
        @(negedge clock);
        cpu_read = rd; cpu_write = wr; cpu_address = addr; cpu_writedata = wdata;
        #1;
        while (cpu_busywait && stalls < Budget) begin
            if (mem_write) begin saw_wb = 1; wb_addr = mem_address; wb_data = mem_writedata; end
            if (mem_read) begin saw_fetch = 1; f_addr = mem_address; end
            stalls++;
            @(negedge clock); #1;
        end
        rdata = cpu_readdata;
        n_cmp++;
        if (stalls >= Budget) begin
            n_bad++;
            $display("FAIL timeout addr=%h: busywait still high after %0d cycles", addr, stalls);
        end
        @(negedge clock);
        cpu_read = 1'b0; cpu_write = 1'b0;
    endtask

    int          st;
    logic        swb, sf;
    logic [5:0]  wa, fa;
    logic [31:0] wd;
    logic [7:0]  rd;

    task automatic test_reset();
        cpu_read = 1'b1; cpu_address = 8'h25;
        reset = 1'b1;
        #1;
        n_cmp++; if (cpu_busywait !== 1'b0) begin n_bad++; $display("FAIL reset_busywait got %b want 0", cpu_busywait); end
        n_cmp++; if (cpu_readdata !== 8'h00) begin n_bad++; $display("FAIL reset_readdata got %h want 00", cpu_readdata); end
        n_cmp++; if (mem_read !== 1'b0) begin n_bad++; $display("FAIL reset_mem_read got %b want 0", mem_read); end
        n_cmp++; if (mem_write !== 1'b0) begin n_bad++; $display("FAIL reset_mem_write got %b want 0", mem_write); end
        n_cmp++; if (mem_address !== 6'h00) begin n_bad++; $display("FAIL reset_mem_address got %h want 00", mem_address); end
        n_cmp++; if (mem_writedata !== 32'h0) begin n_bad++; $display("FAIL reset_mem_writedata got %h want 0", mem_writedata); end
        cpu_read = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_read_miss_clean();
        do_access(1'b1, 1'b0, 8'h25, 8'h00, st, swb, wa, wd, sf, fa, rd);
        n_cmp++; if (swb !== 1'b0) begin n_bad++; $display("FAIL rmiss_no_wb got %b want 0", swb); end
        n_cmp++; if (sf !== 1'b1 || fa !== 6'h09) begin n_bad++; $display("FAIL rmiss_fetch got %b/%h want 1/09", sf, fa); end
        n_cmp++; if (rd !== 8'h49) begin n_bad++; $display("FAIL rmiss_data got %h want 49", rd); end
        n_cmp++; if (st != Lat + 2) begin n_bad++; $display("FAIL rmiss_stall got %0d want %0d", st, Lat + 2); end
    endtask

    task automatic test_write_hit();
        do_access(1'b0, 1'b1, 8'h25, 8'hAB, st, swb, wa, wd, sf, fa, rd);
        n_cmp++; if (st != 0 || swb || sf) begin n_bad++; $display("FAIL whit got stall=%0d wb=%b f=%b want 0/0/0", st, swb, sf); end
        do_access(1'b1, 1'b0, 8'h25, 8'h00, st, swb, wa, wd, sf, fa, rd);
        n_cmp++; if (st != 0) begin n_bad++; $display("FAIL rhit_stall got %0d want 0", st); end
        n_cmp++; if (rd !== 8'hAB) begin n_bad++; $display("FAIL rhit_data got %h want ab", rd); end
    endtask

    task automatic test_dirty_evict();
        do_access(1'b1, 1'b0, 8'hA5, 8'h00, st, swb, wa, wd, sf, fa, rd);
        n_cmp++; if (swb !== 1'b1 || wa !== 6'h09) begin n_bad++; $display("FAIL evict_wb_addr got %b/%h want 1/09", swb, wa); end
        n_cmp++; if (wd !== 32'hC989AB09) begin n_bad++; $display("FAIL evict_wb_data got %h want c989ab09", wd); end
        n_cmp++; if (sf !== 1'b1 || fa !== 6'h29) begin n_bad++; $display("FAIL evict_fetch got %b/%h want 1/29", sf, fa); end
        n_cmp++; if (rd !== 8'h69) begin n_bad++; $display("FAIL evict_data got %h want 69", rd); end
        n_cmp++; if (st != 2 * Lat + 3) begin n_bad++; $display("FAIL evict_stall got %0d want %0d", st, 2 * Lat + 3); end
    endtask

    task automatic test_both_ops();
        @(negedge clock);
        cpu_read = 1'b1; cpu_write = 1'b1; cpu_address = 8'h10; cpu_writedata = 8'hFF;
        #1;
        n_cmp++; if (cpu_busywait !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0) begin
            n_bad++; $display("FAIL both_10 got bw=%b mr=%b mw=%b want 0/0/0", cpu_busywait, mem_read, mem_write);
        end
        cpu_address = 8'hA5;
        #1;
        n_cmp++; if (cpu_busywait !== 1'b0 || cpu_readdata !== 8'h00) begin
            n_bad++; $display("FAIL both_a5 got bw=%b rd=%h want 0/00", cpu_busywait, cpu_readdata);
        end
        @(negedge clock);
        cpu_read = 1'b0; cpu_write = 1'b0;
        do_access(1'b1, 1'b0, 8'hA5, 8'h00, st, swb, wa, wd, sf, fa, rd);
        n_cmp++; if (st != 0 || rd !== 8'h69) begin n_bad++; $display("FAIL both_unchanged got stall=%0d rd=%h want 0/69", st, rd); end
    endtask

    task automatic test_write_miss();
        do_access(1'b0, 1'b1, 8'h03, 8'h5A, st, swb, wa, wd, sf, fa, rd);
        n_cmp++; if (swb !== 1'b0 || sf !== 1'b1 || fa !== 6'h00) begin
            n_bad++; $display("FAIL wmiss got wb=%b f=%b fa=%h want 0/1/00", swb, sf, fa);
        end
        do_access(1'b1, 1'b0, 8'h03, 8'h00, st, swb, wa, wd, sf, fa, rd);
        n_cmp++; if (st != 0 || rd !== 8'h5A) begin n_bad++; $display("FAIL wmiss_read got stall=%0d rd=%h want 0/5a", st, rd); end
        do_access(1'b1, 1'b0, 8'hE3, 8'h00, st, swb, wa, wd, sf, fa, rd);
        n_cmp++; if (swb !== 1'b1 || wa !== 6'h00 || wd !== 32'h5A804000) begin
            n_bad++; $display("FAIL wmiss_evict got wb=%b wa=%h wd=%h want 1/00/5a804000", swb, wa, wd);
        end
        n_cmp++; if (fa !== 6'h38 || rd !== 8'hF8) begin n_bad++; $display("FAIL wmiss_refill got fa=%h rd=%h want 38/f8", fa, rd); end
    endtask

    task automatic test_reset_mid_fetch();
        @(negedge clock);
        cpu_read = 1'b1; cpu_address = 8'h45;
        @(negedge clock); #1;
        n_cmp++; if (mem_read !== 1'b1 || mem_address !== 6'h11) begin
            n_bad++; $display("FAIL midfetch_req got mr=%b ma=%h want 1/11", mem_read, mem_address);
        end
        reset = 1'b1;
        #1;
        n_cmp++; if (mem_read !== 1'b0 || cpu_busywait !== 1'b0) begin
            n_bad++; $display("FAIL midfetch_reset got mr=%b bw=%b want 0/0", mem_read, cpu_busywait);
        end
        cpu_read = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        do_access(1'b1, 1'b0, 8'h45, 8'h00, st, swb, wa, wd, sf, fa, rd);
        n_cmp++; if (sf !== 1'b1 || fa !== 6'h11 || st != Lat + 2 || rd !== 8'h51) begin
            n_bad++; $display("FAIL midfetch_reread got f=%b fa=%h st=%0d rd=%h want 1/11/%0d/51", sf, fa, st, rd, Lat + 2);
        end
        do_access(1'b1, 1'b0, 8'hE3, 8'h00, st, swb, wa, wd, sf, fa, rd);
        n_cmp++; if (swb !== 1'b0 || sf !== 1'b1 || fa !== 6'h38) begin
            n_bad++; $display("FAIL after_reset_miss got wb=%b f=%b fa=%h want 0/1/38", swb, sf, fa);
        end
    endtask

    initial begin
        mem_written = '0;
        test_reset();
        test_read_miss_clean();
        test_write_hit();
        test_dirty_evict();
        test_both_ops();
        test_write_miss();
        test_reset_mid_fetch();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dcache_controller.md
DCACHE_CONTROLLER -- requirements
Module: dcache_controller

Interface
REQ-001 No parameters; geometry fixed at 8 lines x 4 bytes, direct-mapped, write-back, write-allocate.
REQ-002 clock  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high.
REQ-004 cpu_read  input  1  CPU byte read request, level, held until cpu_busywait low.
REQ-005 cpu_write  input  1  CPU byte write request, level, held until cpu_busywait low.
REQ-006 cpu_address  input  8  byte address: tag[7:5], index[4:2], offset[1:0].
REQ-007 cpu_writedata  input  8  write byte.
REQ-008 cpu_readdata  output  8  read byte.
REQ-009 cpu_busywait  output  1  high while the CPU must stall.
REQ-010 mem_read  output  1  block fetch request to backing memory.
REQ-011 mem_write  output  1  block write-back request to backing memory.
REQ-012 mem_address  output  6  block address {tag,index}.
REQ-013 mem_writedata  output  32  write-back block; byte n at bits [8n+7:8n].
REQ-014 mem_readdata  input  32  fetched block, same byte order.
REQ-015 mem_busywait  input  1  backing memory busy; rises combinationally on mem_read/mem_write, falls on completion.

Function
REQ-016 Per line: valid bit, dirty bit, 3-bit tag, 32-bit data.
REQ-017 hit = valid[index] && tag[index]==cpu_address[7:5], combinational.
REQ-018 Access = exactly one of cpu_read/cpu_write high; both high or both low is no access: cpu_busywait 0, no state change.
REQ-019 FSM states IDLE, WRITEBACK, FETCH.
REQ-020 IDLE, read hit: cpu_readdata = selected byte combinationally, cpu_busywait 0 same cycle.
REQ-021 IDLE, write hit: cpu_busywait 0 same cycle; byte written and dirty set at next rising edge.
REQ-022 IDLE with no read hit: cpu_readdata = 8'h00.
REQ-023 IDLE, miss, line invalid or clean: cpu_busywait 1; next edge -> FETCH.
REQ-024 IDLE, miss, line valid and dirty: cpu_busywait 1; next edge -> WRITEBACK.
REQ-025 WRITEBACK: mem_write 1, mem_address {stored tag,index}, mem_writedata stored block; first edge with mem_busywait 0 -> FETCH.
REQ-026 FETCH: mem_read 1, mem_address {cpu tag,index}; first edge with mem_busywait 0 loads mem_readdata, sets tag, valid 1, dirty 0, -> IDLE.
REQ-027 After FETCH, the request resolves as a hit in IDLE (write hit then sets dirty); miss penalty = refill + 1 cycle.
REQ-028 cpu_busywait 1 throughout WRITEBACK and FETCH regardless of CPU inputs.
REQ-029 CPU address/data/op held stable by CPU while cpu_busywait 1; cache does not latch them.
REQ-030 Outside their states mem_read and mem_write are 0; never both 1.
REQ-031 mem_busywait low on FSM entry to WRITEBACK/FETCH does not bypass one-edge residency.

Reset
REQ-032 Asserting reset immediately, at any time: state IDLE, all valid/dirty bits 0, tags 0, data 0.
REQ-033 Reset outputs: cpu_busywait 0, cpu_readdata 8'h00, mem_read 0, mem_write 0, mem_address 0, mem_writedata 0.
REQ-034 Reset mid-WRITEBACK/FETCH abandons the transfer; no line updated; dirty data lost.
REQ-035 After reset deassertion, first access to any address misses.

Verification
REQ-036 After reset, read 0x25 -> FETCH mem_address 6'h09, no WRITEBACK; after refill cpu_readdata = byte 1 of mem block 0x09, busywait drops.
REQ-037 Write 0xAB to 0x25 following REQ-036 -> hit, cpu_busywait 0, no mem request; read 0x25 -> 0xAB with zero stall.
REQ-038 Then read 0xA5 (same index 1, tag 5) -> WRITEBACK mem_address 6'h09 with byte 1 = 0xAB, then FETCH mem_address 6'h29.
REQ-039 cpu_read and cpu_write both high at 0x10 -> cpu_busywait 0, mem_read/mem_write 0, no line change.
REQ-040 Reset asserted mid-FETCH -> mem_read falls without waiting for clock, cpu_busywait 0; re-reading same address misses again.
REQ-041 Write miss to invalid line 0x03 with 0x5A -> FETCH 6'h00, then line dirty with byte 3 = 0x5A; later eviction writes back 0x5A in bits [31:24].
